// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the write port of an 8-bit synchronous FIFO
// among NUM_REQ producers. A producer wins the port for a burst of at most
// BURST_MAX words. The FIFO's full flag is used as back-pressure, so no write
// is ever issued while the FIFO is full.
//
// Ports:
//   clk          - rising-edge clock, shared with the FIFO
//   reset        - asynchronous, active-low reset
//   req_valid    - per-producer "word available" flags
//   req_data     - producer i's word sits at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    - combinational; word i is taken when req_valid[i] & req_ready[i]
//   full_flag    - FIFO full
//   write_enable - combinational FIFO write strobe
//   w_data       - combinational FIFO write data
//   grant        - registered one-hot owner, all-zero when idle
//   busy         - registered, high while a grant is held
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full_flag,
    output logic                          write_enable,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    // Last owner resets to the highest index so that requester 0 wins first.
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(BURST_MAX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     lastOwner_q, lastOwner_d;
    logic [CNT_W-1:0]     beatCnt_q, beatCnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 busy_q, busy_d;

    logic [IDX_W-1:0]     winner;
    logic [IDX_W:0]       candSum;
    logic [IDX_W-1:0]     candIdx;
    logic                 anyReq;
    logic                 ownerValid;
    logic                 accept;

    // Round-robin pick. Candidates are walked from the farthest position
    // (last owner itself) towards the nearest (last owner + 1), so the final
    // assignment that sticks is the first requester after the last owner.
    always_comb begin
        winner  = lastOwner_q;
        candSum = '0;
        candIdx = '0;
        anyReq  = |req_valid;
        for (int k = NUM_REQ; k >= 1; k--) begin
            candSum = {1'b0, lastOwner_q} + (IDX_W + 1)'(k);
            if (candSum >= (IDX_W + 1)'(NUM_REQ)) begin
                candSum = candSum - (IDX_W + 1)'(NUM_REQ);
            end
            candIdx = candSum[IDX_W-1:0];
            if (req_valid[candIdx]) begin
                winner = candIdx;
            end
        end
    end

    // Write-port datapath. The owner's ready follows ~full_flag directly, so
    // a write can never coincide with a full FIFO, and the first accept after
    // full falls happens in that same cycle.
    always_comb begin
        req_ready    = '0;
        w_data       = '0;
        ownerValid   = req_valid[owner_q];
        accept       = 1'b0;
        write_enable = 1'b0;
        if (state_q == GRANT) begin
            accept       = ownerValid & ~full_flag;
            write_enable = accept;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (IDX_W'(i) == owner_q) begin
                    req_ready[i] = ~full_flag;
                    w_data       = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Next-state logic. A grant ends on burst exhaustion or when the owner
    // drops valid; a stall on full simply holds state and beat count.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        beatCnt_d   = beatCnt_q;
        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    owner_d     = winner;
                    lastOwner_d = winner;
                    beatCnt_d   = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (!ownerValid) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (beatCnt_q == BEAT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        beatCnt_d = beatCnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d  = (state_d == GRANT);
        grant_d = busy_d ? (NUM_REQ'(1) << owner_d) : '0;
    end

    // State registers. Reset drops any grant at once; a partial burst is
    // simply abandoned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            lastOwner_q <= LAST_RESET;
            beatCnt_q   <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
            beatCnt_q   <= beatCnt_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule
